bcd_serial_sub_ctrl: RTL and testbench
======================================

BCD_SERIAL_SUB_CTRL -- requirements
Module: bcd_serial_sub_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 2..8).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port START, input, 1 bit: request a subtraction; sampled on the rising edge of CLK.
REQ-005 SHALL have port A, input, 4*DIGITS bits: BCD minuend, digit 0 in bits [3:0].
REQ-006 SHALL have port B, input, 4*DIGITS bits: BCD subtrahend, same digit layout as A.
REQ-007 SHALL have port S, output, 4*DIGITS bits: BCD magnitude |A-B|, registered.
REQ-008 SHALL have port NEG, output, 1 bit: high when A<B, registered.
REQ-009 SHALL have port ERR, output, 1 bit: high when an operand nibble was >9, registered.
REQ-010 SHALL have port BUSY, output, 1 bit: high while a computation is in progress.
REQ-011 SHALL have port DONE, output, 1 bit: single-cycle completion pulse.

Function
REQ-012 SHALL contain exactly one shared single-digit BCD subtract stage: d = a - b - bin; if d<0 then d += 10 and bout=1, else bout=0.
REQ-013 SHALL implement four states: IDLE, SUB, COMP, FIN.
REQ-014 SHALL accept START only in IDLE or FIN; at that edge: latch A and B, clear the borrow, set the digit counter to 0.
REQ-015 SHALL ignore START in SUB and COMP, with no effect on the operation in progress.
REQ-016 SHALL, on accepting START with any nibble of A or B >9, go directly to FIN with ERR=1, S=0 and NEG=0, and perform no SUB cycles.
REQ-017 SHALL, in SUB, process one digit per cycle, least-significant digit first, a_i - b_i - borrow, writing the result digit to an internal working register; SUB lasts exactly DIGITS cycles.
REQ-018 SHALL, after the last SUB digit, go to FIN if the final borrow is 0, else to COMP with the borrow cleared and the counter reset.
REQ-019 SHALL, in COMP, reuse the same stage with a=0 and b=working digit i, for DIGITS cycles, producing the tens-complement (the magnitude).
REQ-020 SHALL, on entry to FIN, update S from the working register and set NEG=1 only on the COMP path; S, NEG and ERR hold until the next accepted START completes.
REQ-021 SHALL assert DONE for exactly one cycle, while in FIN; FIN returns to IDLE on the next edge unless START is accepted there.
REQ-022 SHALL assert BUSY exactly in SUB and COMP, and deassert it in IDLE and FIN.
REQ-023 SHALL give latency, counted from the START-accepting edge k to the edge that asserts DONE: 1 for ERR, DIGITS+1 for non-negative results, 2*DIGITS+1 for negative results.
REQ-024 SHALL produce S=0, NEG=0 when A==B; negative zero SHALL never occur.
REQ-025 SHALL produce only legal BCD digits (0..9) on every digit of S.

Reset
REQ-026 SHALL, while nRST is low, immediately force state=IDLE, S=0, NEG=0, ERR=0, BUSY=0, DONE=0, and clear the working register, counter and borrow, independent of CLK.
REQ-027 SHALL abandon any operation interrupted by reset, with no DONE issued; the first START after nRST rises is accepted normally.

Verification (DIGITS=4)
REQ-028 SHALL cover: A=0x5321, B=0x1234 -> S=0x4087, NEG=0, ERR=0; DONE 5 edges after START; BUSY high for 4 cycles.
REQ-029 SHALL cover: A=0x1234, B=0x5321 -> S=0x4087, NEG=1; DONE 9 edges after START; BUSY high for 8 cycles.
REQ-030 SHALL cover: A=0x0000, B=0x0001 -> S=0x0001, NEG=1; and A=B=0x9999 -> S=0x0000, NEG=0, DONE after 5 edges.
REQ-031 SHALL cover: A=0x12A4, B=0x0001 -> ERR=1, S=0, NEG=0, DONE 1 edge after START, BUSY never high.
REQ-032 SHALL cover: nRST pulsed low during the 2nd SUB cycle -> all outputs 0 at once, no DONE; a following START with A=0x0010, B=0x0001 -> S=0x0009, NEG=0.
REQ-033 SHALL cover: START held high continuously across operations -> mid-operation STARTs ignored; a new operation is accepted in the FIN cycle, so DONE pulses recur every 5 cycles for non-negative operands.

Source files
------------

// File: rtl/bcd_serial_sub_ctrl.sv
// Serial BCD subtractor: one shared digit stage computes |A-B| digit by digit,
// with a second pass to tens-complement the result when the first pass borrows out.
module bcd_serial_sub_ctrl #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                START,
   input  logic [4*DIGITS-1:0] A,
   input  logic [4*DIGITS-1:0] B,
   output logic [4*DIGITS-1:0] S,
   output logic                NEG,
   output logic                ERR,
   output logic                BUSY,
   output logic                DONE
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      COMP = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    work;
   logic [CW-1:0]   cnt;
   logic            borrow;

   logic            bad_c;
   logic [3:0]      sa_c;
   logic [3:0]      sb_c;
   logic [4:0]      diff_c;
   logic [3:0]      sd_c;
   logic            bout_c;
   logic            last_c;

   // Any non-BCD nibble in either operand
   always_comb begin
      bad_c = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_c = 1'b1;
      end
   end

   // Shared digit stage; COMP reuses it as 0 - work[i] - borrow
   always_comb begin
      sa_c   = (state == COMP) ? 4'd0 : a_q[4*cnt +: 4];
      sb_c   = (state == COMP) ? work[4*cnt +: 4] : b_q[4*cnt +: 4];
      diff_c = 5'(sa_c) - 5'(sb_c) - 5'(borrow);
      bout_c = diff_c[4];
      sd_c   = bout_c ? 4'(diff_c + 5'd10) : diff_c[3:0];
      last_c = (cnt == CW'(DIGITS - 1));
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         work   <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         S      <= '0;
         NEG    <= 1'b0;
         ERR    <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (START) begin
                  a_q    <= A;
                  b_q    <= B;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  if (bad_c) begin
                     state <= FIN;
                     S     <= '0;
                     NEG   <= 1'b0;
                     ERR   <= 1'b1;
                     DONE  <= 1'b1;
                     BUSY  <= 1'b0;
                  end else begin
                     state <= SUB;
                     BUSY  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            end
            SUB: begin
               work[4*cnt +: 4] <= sd_c;
               borrow           <= bout_c;
               cnt              <= cnt + CW'(1);
               if (last_c) begin
                  cnt <= '0;
                  if (!bout_c) begin
                     state <= FIN;
                     S     <= {sd_c, work[W-5:0]};
                     NEG   <= 1'b0;
                     ERR   <= 1'b0;
                     DONE  <= 1'b1;
                     BUSY  <= 1'b0;
                  end else begin
                     state  <= COMP;
                     borrow <= 1'b0;
                  end
               end
            end
            COMP: begin
               work[4*cnt +: 4] <= sd_c;
               borrow           <= bout_c;
               cnt              <= cnt + CW'(1);
               if (last_c) begin
                  cnt   <= '0;
                  state <= FIN;
                  S     <= {sd_c, work[W-5:0]};
                  NEG   <= 1'b1;
                  ERR   <= 1'b0;
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
// Directed bench for bcd_serial_sub_ctrl with DIGITS=4: results, flags, latency,
// BUSY occupancy, error path, mid-operation reset and back-to-back START.
module tb_bcd_serial_sub_ctrl;

   logic        CLK;
   logic        nRST;
   logic        START;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] S;
   logic        NEG;
   logic        ERR;
   logic        BUSY;
   logic        DONE;

   int vectors;
   int miscompares;

   bcd_serial_sub_ctrl #(.DIGITS(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .START(START),
      .A    (A),
      .B    (B),
      .S    (S),
      .NEG  (NEG),
      .ERR  (ERR),
      .BUSY (BUSY),
      .DONE (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Latency counts edges from the accepting edge k up to and including the
   // edge at which DONE is first sampled high.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_s, input logic exp_neg, input logic exp_err,
                         input int exp_lat, input int exp_busy);
      int lat;
      int busy_cnt;
      @(negedge CLK);
      A = a;
      B = b;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!DONE && lat < 40) begin
         if (BUSY) busy_cnt++;
         @(posedge CLK);
         #1;
         lat++;
      end
      chk({tag, "_lat"},  32'(lat),      32'(exp_lat));
      chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
      chk({tag, "_s"},    32'(S),        32'(exp_s));
      chk({tag, "_neg"},  32'(NEG),      32'(exp_neg));
      chk({tag, "_err"},  32'(ERR),      32'(exp_err));
      chk({tag, "_busy_fin"}, 32'(BUSY), 32'd0);
      @(posedge CLK);
      #1;
      chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
      chk({tag, "_s_hold"},     32'(S),    32'(exp_s));
   endtask

   initial begin
      int done_seen;
      vectors     = 0;
      miscompares = 0;
      nRST  = 1'b1;
      START = 1'b0;
      A     = '0;
      B     = '0;
      #2 nRST = 1'b0;
      #1;
      chk("reset_outs", 32'({S, NEG, ERR, BUSY, DONE}), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      run_op("pos_5321_1234", 16'h5321, 16'h1234, 16'h4087, 1'b0, 1'b0, 5, 4);
      run_op("neg_1234_5321", 16'h1234, 16'h5321, 16'h4087, 1'b1, 1'b0, 9, 8);
      run_op("neg_0000_0001", 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9, 8);
      run_op("eq_9999",       16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5, 4);
      run_op("pos_0100_0099", 16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, 5, 4);
      run_op("err_12a4",      16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 0);

      // Reset during the second SUB cycle; previous S (0) is replaced first
      run_op("pre_rst",       16'h0042, 16'h0010, 16'h0032, 1'b0, 1'b0, 5, 4);
      @(negedge CLK);
      A = 16'h5321;
      B = 16'h1234;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      @(posedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      chk("rst_mid_outs", 32'({S, NEG, ERR, BUSY, DONE}), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK);
         #1;
         if (DONE) done_seen++;
      end
      chk("rst_no_done", 32'(done_seen), 32'd0);
      run_op("post_rst_0010_0001", 16'h0010, 16'h0001, 16'h0009, 1'b0, 1'b0, 5, 4);

      // START held high: ops accepted only in FIN, DONE every 5 cycles
      @(negedge CLK);
      A = 16'h5321;
      B = 16'h1234;
      START = 1'b1;
      @(posedge CLK);
      #1;
      for (int j = 1; j <= 15; j++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("held_done_%0d", j), 32'(DONE), ((j % 5) == 4) ? 32'd1 : 32'd0);
         if ((j % 5) == 4) chk($sformatf("held_s_%0d", j), 32'(S), 32'h4087);
      end
      START = 1'b0;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      chk("held_idle_busy", 32'(BUSY), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
